output_alloc: RTL and testbench

Per-output-port switch allocator for the router. It arbitrates among the five input ports (local, N, E, S, W) that request this output and drives the one-hot `sel` consumed by the output crossbar mux. It also returns per-input grants to the input buffers and tracks downstream per-VC credits. Wormhole packets are held to one input from head flit to tail flit.

---
 rtl/noc_pkg.sv | 21 ++
 rtl/rr_arb.sv | 29 ++
 rtl/output_alloc.sv | 156 +++++++++++++++
 tb/tb_output_alloc.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// noc_pkg: shared router constants and types.
//   PORT_N        highest port index (five ports: local, N, E, S, W)
//   VC_N          virtual channels per link
//   VCW           VC index width (at least 1)
//   BUF_DEPTH     downstream buffer slots per VC (initial credit value)
//   cred_t        credit counter type, wide enough to hold BUF_DEPTH
//   alloc_state_e output allocator lock state
package noc_pkg;
    localparam int PORT_N    = 4;
    localparam int VC_N      = 2;
    localparam int VCW       = (VC_N > 1) ? $clog2(VC_N) : 1;
    localparam int BUF_DEPTH = 4;
    localparam int CREDW     = $clog2(BUF_DEPTH + 1);

    typedef logic [CREDW-1:0] cred_t;

    typedef enum logic [0:0] {
        ALLOC_IDLE   = 1'b0,
        ALLOC_LOCKED = 1'b1
    } alloc_state_e;
endpackage

// File: rtl/rr_arb.sv
// rr_arb: combinational rotating-priority arbiter.
// Scans the eligible vector starting at i_ptr, wrapping from N-1 to 0,
// and returns the first eligible requester as a one-hot vector.
//   i_elig  [N-1:0]   eligible requesters
//   i_ptr   [PW-1:0]  index holding highest priority this cycle
//   o_win   [N-1:0]   one-hot winner, all-zero when nothing is eligible
module rr_arb #(
    parameter int N  = 5,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  i_elig,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_win
);
    always_comb begin
        logic [PW-1:0] idx;
        logic          found;
        o_win = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            idx = PW'((int'(i_ptr) + k) % N);
            if (!found && i_elig[idx]) begin
                o_win[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end
endmodule

// File: rtl/output_alloc.sv
// output_alloc: per-output-port switch allocator.
// Arbitrates round-robin among the five input ports requesting this output,
// holds a wormhole packet on one input from head to tail, and (optionally)
// tracks downstream per-VC credits.
// Build option: define NOC_CREDIT_EN to build the credit counters; without
// it every requester is eligible and credit inputs are ignored.
//   clk, rst_n    clock, asynchronous active-low reset
//   req           input i has a flit for this output
//   req_vch       VC of each requesting flit
//   req_tail      requesting flit is a tail
//   credit_valid  downstream freed one slot on credit_vch
//   sel           one-hot crossbar select (combinational)
//   grant         pop strobe to input buffers, equal to sel
//   locked        a packet currently owns the output
module output_alloc #(
    parameter int  PORT_N    = noc_pkg::PORT_N,
    parameter int  VC_N      = noc_pkg::VC_N,
    parameter int  BUF_DEPTH = noc_pkg::BUF_DEPTH,
    localparam int VCW       = (VC_N > 1) ? $clog2(VC_N) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [PORT_N:0]           req,
    input  logic [PORT_N:0][VCW-1:0]  req_vch,
    input  logic [PORT_N:0]           req_tail,
    input  logic                      credit_valid,
    input  logic [VCW-1:0]            credit_vch,
    output logic [PORT_N:0]           sel,
    output logic [PORT_N:0]           grant,
    output logic                      locked
);
    import noc_pkg::*;

    localparam int NP    = PORT_N + 1;
    localparam int PW    = $clog2(NP);
    localparam int CREDW = $clog2(BUF_DEPTH + 1);

    alloc_state_e  r_state;
    logic [PW-1:0] r_owner;
    logic [PW-1:0] r_rr_ptr;

    logic [NP-1:0] w_elig;
    logic [NP-1:0] w_arb_win;
    logic [NP-1:0] w_sel;
    logic [PW-1:0] w_win_idx;
    logic          w_any;
    logic          w_win_tail;
    logic          w_owner_elig;

`ifdef NOC_CREDIT_EN
    logic [VCW-1:0]   r_owner_vch;
    logic [CREDW-1:0] r_cred [VC_N];
    logic [VCW-1:0]   w_gnt_vch;
    logic [VC_N-1:0]  w_dec;
    logic [VC_N-1:0]  w_inc;

    always_comb begin
        for (int i = 0; i < NP; i++) begin
            w_elig[i] = req[i] && (r_cred[req_vch[i]] != '0);
        end
    end

    // The owner's VC is fixed for the whole packet, so check its recorded VC.
    assign w_owner_elig = req[r_owner] && (r_cred[r_owner_vch] != '0);
    assign w_gnt_vch    = (r_state == ALLOC_IDLE) ? req_vch[w_win_idx] : r_owner_vch;

    always_comb begin
        for (int v = 0; v < VC_N; v++) begin
            w_dec[v] = w_any && (w_gnt_vch == VCW'(v));
            w_inc[v] = credit_valid && (credit_vch == VCW'(v));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner_vch <= '0;
        end else if (w_any && (r_state == ALLOC_IDLE)) begin
            r_owner_vch <= req_vch[w_win_idx];
        end
    end

    // A grant and a return on the same VC cancel out; a return into a full
    // counter is a downstream error and is dropped (saturate).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int v = 0; v < VC_N; v++) r_cred[v] <= CREDW'(BUF_DEPTH);
        end else begin
            for (int v = 0; v < VC_N; v++) begin
                if (w_inc[v] && !w_dec[v] && (r_cred[v] != CREDW'(BUF_DEPTH)))
                    r_cred[v] <= r_cred[v] + CREDW'(1);
                else if (w_dec[v] && !w_inc[v])
                    r_cred[v] <= r_cred[v] - CREDW'(1);
            end
        end
    end
`else
    logic w_unused_credit;

    assign w_elig          = req;
    assign w_owner_elig    = req[r_owner];
    assign w_unused_credit = ^{credit_valid, credit_vch, req_vch};
`endif

    rr_arb #(
        .N  (NP),
        .PW (PW)
    ) u_rr_arb (
        .i_elig (w_elig),
        .i_ptr  (r_rr_ptr),
        .o_win  (w_arb_win)
    );

    // Select is forced low while reset is asserted so the crossbar goes idle
    // immediately, not at the next clock.
    always_comb begin
        w_sel = '0;
        if (!rst_n)
            w_sel = '0;
        else if (r_state == ALLOC_IDLE)
            w_sel = w_arb_win;
        else
            w_sel[r_owner] = w_owner_elig;
    end

    always_comb begin
        w_win_idx = '0;
        for (int i = 0; i < NP; i++) begin
            if (w_sel[i]) w_win_idx = PW'(i);
        end
    end

    assign w_any      = |w_sel;
    assign w_win_tail = req_tail[w_win_idx];

    // Pointer only moves on an IDLE grant; during a packet it already
    // points past the owner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ALLOC_IDLE;
            r_owner  <= '0;
            r_rr_ptr <= '0;
        end else if (w_any) begin
            if (r_state == ALLOC_IDLE) begin
                r_rr_ptr <= (w_win_idx == PW'(PORT_N)) ? '0 : w_win_idx + PW'(1);
                r_owner  <= w_win_idx;
                if (!w_win_tail) r_state <= ALLOC_LOCKED;
            end else if (w_win_tail) begin
                r_state <= ALLOC_IDLE;
            end
        end
    end

    assign sel    = w_sel;
    assign grant  = w_sel;
    assign locked = (r_state == ALLOC_LOCKED);
endmodule

// File: tb/tb_output_alloc.sv
module tb_output_alloc;
    import noc_pkg::*;

    localparam int NP = PORT_N + 1;
`ifdef NOC_CREDIT_EN
    localparam bit CRED = 1'b1;
`else
    localparam bit CRED = 1'b0;
`endif

    logic                     clk;
    logic                     rst_n;
    logic [PORT_N:0]          req;
    logic [PORT_N:0][VCW-1:0] req_vch;
    logic [PORT_N:0]          req_tail;
    logic                     credit_valid;
    logic [VCW-1:0]           credit_vch;
    logic [PORT_N:0]          sel;
    logic [PORT_N:0]          grant;
    logic                     locked;

    output_alloc dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .req_vch      (req_vch),
        .req_tail     (req_tail),
        .credit_valid (credit_valid),
        .credit_vch   (credit_vch),
        .sel          (sel),
        .grant        (grant),
        .locked       (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: allocator state expressed as plain integers.
    bit m_lock;
    int m_owner;
    int m_ptr;
    int m_cred [VC_N];
    int last_win;

    task automatic m_reset();
        m_lock  = 1'b0;
        m_owner = 0;
        m_ptr   = 0;
        for (int v = 0; v < VC_N; v++) m_cred[v] = BUF_DEPTH;
    endtask

    function automatic bit m_elig(int i);
        return req[i] && (!CRED || m_cred[int'(req_vch[i])] > 0);
    endfunction

    function automatic int m_pick();
        int w;
        w = -1;
        if (!m_lock) begin
            for (int k = 0; k < NP; k++) begin
                if (w < 0 && m_elig((m_ptr + k) % NP)) w = (m_ptr + k) % NP;
            end
        end else if (m_elig(m_owner)) begin
            w = m_owner;
        end
        return w;
    endfunction

    // Called at a falling edge with inputs already driven: checks outputs
    // against the model, advances the model, waits for the next falling edge.
    task automatic tick(input string tag);
        int w;
        logic [PORT_N:0] exp_sel;
        #1;
        w = m_pick();
        exp_sel = '0;
        if (w >= 0) exp_sel[w] = 1'b1;
        chk({tag, ".sel"}, sel, exp_sel);
        chk({tag, ".grant"}, grant, exp_sel);
        chk({tag, ".locked"}, locked, m_lock);
        for (int v = 0; v < VC_N; v++) begin
            int dec, inc;
            dec = (w >= 0 && int'(req_vch[w]) == v) ? 1 : 0;
            inc = (credit_valid && int'(credit_vch) == v) ? 1 : 0;
            m_cred[v] = m_cred[v] - dec + inc;
            if (m_cred[v] > BUF_DEPTH) m_cred[v] = BUF_DEPTH;
        end
        if (w >= 0) begin
            if (!m_lock) begin
                m_ptr = (w + 1) % NP;
                if (!req_tail[w]) begin
                    m_lock  = 1'b1;
                    m_owner = w;
                end
            end else if (req_tail[w]) begin
                m_lock = 1'b0;
            end
        end
        last_win = w;
        @(negedge clk);
    endtask

    task automatic drv(input logic [PORT_N:0] r, input logic [PORT_N:0] t,
                       input logic [PORT_N:0][VCW-1:0] v);
        req          = r;
        req_tail     = t;
        req_vch      = v;
        credit_valid = 1'b0;
        credit_vch   = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        m_reset();
        drv('0, '0, '0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [PORT_N:0][VCW-1:0] vv;
    int                       rem [NP];
    logic [VCW-1:0]           pv  [NP];

    initial begin
        rst_n = 1'b1;
        m_reset();
        drv(5'b11111, 5'b11111, '0);
        #2 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst.sel", sel, 0);
        chk("rst.grant", grant, 0);
        chk("rst.locked", locked, 0);
        @(negedge clk);
        rst_n = 1'b1;
        drv('0, '0, '0);

        // Round-robin from reset, with wrap
        drv(5'b10010, 5'b10010, '0);
        #1 chk("rr.first", sel, 5'b00010);
        tick("rr1");
        #1 chk("rr.second", sel, 5'b10000);
        tick("rr2");
        #1 chk("rr.wrap", sel, 5'b00010);
        tick("rr3");

        // Wormhole lock: input 2 four-flit packet on VC1, input 3 waiting
        do_reset();
        vv = '0;
        vv[2] = VCW'(1);
        for (int f = 0; f < 4; f++) begin
            drv(5'b01100, (f == 3) ? 5'b01100 : 5'b01000, vv);
            #1 chk("wh.sel", sel, 5'b00100);
            chk("wh.locked", locked, (f == 0) ? 0 : 1);
            tick("wh");
        end
        drv(5'b01000, 5'b01000, '0);
        #1 chk("wh.next", sel, 5'b01000);
        chk("wh.unlocked", locked, 0);
        tick("wh5");

        // Owner bubble on input 4 while input 1 requests
        do_reset();
        drv(5'b10000, 5'b00000, '0);
        #1 chk("bub.head", sel, 5'b10000);
        tick("bub0");
        for (int b = 0; b < 2; b++) begin
            drv(5'b00010, 5'b00010, '0);
            #1 chk("bub.sel", sel, 0);
            chk("bub.locked", locked, 1);
            tick("bub");
        end
        drv(5'b10010, 5'b10010, '0);
        #1 chk("bub.resume", sel, 5'b10000);
        tick("bub3");
        #1 chk("bub.after", sel, 5'b00010);
        tick("bub4");

        // Asynchronous reset while locked
        do_reset();
        drv(5'b00100, 5'b00000, '0);
        tick("ar.head");
        drv(5'b00100, 5'b00000, '0);
        #1 chk("ar.pre_locked", locked, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("ar.sel", sel, 0);
        chk("ar.locked", locked, 0);
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;

`ifdef NOC_CREDIT_EN
        // Credit starvation on VC0 right after reset (counters restored)
        for (int k = 0; k < 6; k++) begin
            drv(5'b00001, 5'b00001, '0);
            #1 chk("st.sel", sel, (k < 4) ? 1 : 0);
            tick("st");
        end
        drv(5'b00001, 5'b00001, '0);
        credit_valid = 1'b1;
        credit_vch   = '0;
        #1 chk("st.nobypass", sel, 0);
        tick("st.cr");
        drv(5'b00001, 5'b00001, '0);
        #1 chk("st.regrant", sel, 1);
        tick("st.rg");
        #1 chk("st.again", sel, 0);
        tick("st.ag");

        // Grant and credit return on VC1 in the same cycle
        do_reset();
        vv = '0;
        vv[1] = VCW'(1);
        for (int k = 0; k < 6; k++) begin
            drv(5'b00010, 5'b00010, vv);
            if (k == 2) begin
                credit_valid = 1'b1;
                credit_vch   = VCW'(1);
            end
            #1 chk("sim.sel", sel, (k < 5) ? 5'b00010 : 0);
            tick("sim");
        end
`endif

        // Randomized packet traffic against the model
        do_reset();
        for (int i = 0; i < NP; i++) begin
            rem[i] = 0;
            pv[i]  = '0;
        end
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NP; i++) begin
                if (rem[i] == 0 && $urandom_range(2) == 0) begin
                    rem[i] = $urandom_range(4, 1);
                    pv[i]  = VCW'($urandom_range(VC_N - 1));
                end
                req[i]      = (rem[i] > 0) && ($urandom_range(3) != 0);
                req_tail[i] = (rem[i] == 1);
                req_vch[i]  = pv[i];
            end
            credit_valid = ($urandom_range(1) == 1);
            credit_vch   = VCW'($urandom_range(VC_N - 1));
            tick("rnd");
            if (last_win >= 0) rem[last_win]--;
            if (c == 1500) begin
                do_reset();
                for (int i = 0; i < NP; i++) rem[i] = 0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
